// File: rtl/store_buffer_lsu_pkg.sv
// Shared types and defaults for the store_buffer_lsu block: word/address widths,
// FIFO sizing defaults and the RUN/FLUSH state encoding.
package store_buffer_lsu_pkg;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 16;
  localparam int DEPTH_DEF   = 4;
  localparam int MATCH_W_DEF = 3;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/store_buffer_lsu_sb_fifo.sv
// Posted-store FIFO: storage, wrapping pointers, occupancy and a per-entry
// low-address match vector. With STORE_FORWARD_EN it also exposes entry data and wr_ptr.
module sb_fifo
  import store_buffer_lsu_pkg::*;
#(
  parameter  int DEPTH   = DEPTH_DEF,
  parameter  int MATCH_W = MATCH_W_DEF,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  addr_t              push_addr,
  input  word_t              push_data,
  input  logic [MATCH_W-1:0] cmp_addr,
  output addr_t              head_addr,
  output word_t              head_data,
  output logic [CNT_W-1:0]   count,
  output logic [DEPTH-1:0]   match
`ifdef STORE_FORWARD_EN
  ,
  output logic [DEPTH-1:0][DATA_W-1:0] entry_data,
  output logic [PTR_W-1:0]             wr_ptr_o
`endif
);

  addr_t             addr_q [DEPTH];
  word_t             data_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  offs [DEPTH];

  // NOTE: state uses non-blocking (<=) so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  // NOTE: storage is not reset; an entry is live only while inside the rd_ptr..count window.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs[i]  = PTR_W'(i) - rd_ptr;
      match[i] = ({1'b0, offs[i]} < count_q) &&
                 (addr_q[i][MATCH_W-1:0] == cmp_addr);
    end
  end

  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign count     = count_q;

`ifdef STORE_FORWARD_EN
  always_comb begin
    entry_data = '0;
    for (int i = 0; i < DEPTH; i++) entry_data[i] = data_q[i];
  end
  assign wr_ptr_o = wr_ptr;
`endif

endmodule

// File: rtl/store_buffer_lsu.sv
// Load/store unit with a posted-store buffer in front of Data_Memory.
// Optional macro STORE_FORWARD_EN: hazarding loads are served from the buffer instead of stalling.
module store_buffer_lsu
  import store_buffer_lsu_pkg::*;
#(
  parameter  int DEPTH   = DEPTH_DEF,
  parameter  int MATCH_W = MATCH_W_DEF,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_write,
  input  addr_t            req_addr,
  input  word_t            req_wdata,
  output logic             req_ready,
  output word_t            rd_data,
  output logic             rd_valid,
  input  logic             flush,
  output logic             flush_done,
  output logic [CNT_W-1:0] sb_count,
  output addr_t            mem_access_addr,
  output word_t            mem_write_data,
  output logic             mem_write_en,
  output logic             mem_read,
  input  word_t            mem_read_data
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] match;
  addr_t            head_addr;
  word_t            head_data;
  logic             hazard, full, load_req, load_port, load_done, drain, push;

  assign hazard    = |match;
  assign full      = (count == CNT_W'(DEPTH));
  assign load_req  = req_valid && !req_write && (state == ST_RUN);
  assign load_port = load_req && !hazard;

  // A hazarding load frees the port either way: it stalls, or it is forwarded.
  assign drain = !rst && (count != '0) && !load_port &&
                 (!req_valid || full || (state == ST_FLUSH) || (load_req && hazard));
  assign push  = !rst && req_valid && req_write && (state == ST_RUN) && (!full || drain);

`ifdef STORE_FORWARD_EN
  logic [DEPTH-1:0][DATA_W-1:0] entry_data;
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             fwd_idx;
  logic                         fwd_found;
  word_t                        fwd_data;

  // Scan back from the newest entry so the youngest matching store wins.
  always_comb begin
    fwd_data  = '0;
    fwd_idx   = '0;
    fwd_found = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      fwd_idx = wr_ptr - PTR_W'(k);
      if (!fwd_found && match[fwd_idx]) begin
        fwd_data  = entry_data[fwd_idx];
        fwd_found = 1'b1;
      end
    end
  end

  assign load_done = load_req;
  assign rd_data   = hazard ? fwd_data : mem_read_data;
`else
  assign load_done = load_port;
  assign rd_data   = mem_read_data;
`endif

  sb_fifo #(.DEPTH(DEPTH), .MATCH_W(MATCH_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (drain),
    .push_addr (req_addr),
    .push_data (req_wdata),
    .cmp_addr  (req_addr[MATCH_W-1:0]),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count),
    .match     (match)
`ifdef STORE_FORWARD_EN
    ,
    .entry_data(entry_data),
    .wr_ptr_o  (wr_ptr)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    flush_done = 1'b0;
    case (state)
      ST_RUN:   if (flush) state_nxt = ST_FLUSH;
      ST_FLUSH: begin
        if ((count == '0) || ((count == CNT_W'(1)) && drain)) begin
          state_nxt  = ST_RUN;
          flush_done = 1'b1;
        end
      end
      default:  state_nxt = ST_RUN;
    endcase
  end

  // Stores are always accepted in RUN (a full buffer drains in the same cycle).
  assign req_ready       = (state == ST_RUN) && !(load_req && !load_done);
  assign rd_valid        = load_done && !rst;
  assign mem_read        = load_port && !rst;
  assign mem_access_addr = load_port ? req_addr : head_addr;
  assign mem_write_data  = head_data;
  assign mem_write_en    = drain;
  assign sb_count        = count;

endmodule
